alu_exec_pipe: RTL and testbench

Registered, handshaked successor to the combinational ALU control unit: decodes `opCode`/`funct` into the 4-bit ALU operation and executes it on `WIDTH`-bit operands. It adds valid/ready flow control, a single-entry output register, signed compare and an iterative one-bit-per-cycle shifter. It sits between the register-read stage and the memory/writeback stage of the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_decode.sv | 60 ++++++
 rtl/alu_exec_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_exec_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, 4-bit ALU operation codes and the
// execute-pipe FSM state encoding.
package alu_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1101;
   localparam logic [3:0] ALU_ILL = 4'b1111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opCode/funct decode into the 4-bit ALU operation plus an
// illegal flag; shared with the single-cycle datapath.
module alu_decode
   import alu_pkg::*;
(
   input  logic [6:0] opCode,
   input  logic [3:0] funct,
   output logic [3:0] operation,
   output logic       illegal
);

   // Returns {illegal, operation} for an R-type style funct field.
   function automatic logic [4:0] decode_funct(input logic [3:0] f);
      case (f)
         4'b0000: return {1'b0, ALU_ADD};
         4'b1000: return {1'b0, ALU_SUB};
         4'b0111: return {1'b0, ALU_AND};
         4'b0110: return {1'b0, ALU_OR};
         4'b0100: return {1'b0, ALU_XOR};
         4'b0010: return {1'b0, ALU_SLT};
         4'b0001: return {1'b0, ALU_SLL};
         4'b0101: return {1'b0, ALU_SRL};
         4'b1101: return {1'b0, ALU_SRA};
         default: return {1'b1, ALU_ILL};
      endcase
   endfunction

   logic [3:0] f_eff;
   logic [4:0] f_dec;

   always_comb begin
      operation = ALU_ILL;
      illegal   = 1'b1;
      f_eff     = funct;
      f_dec     = {1'b1, ALU_ILL};
      case (opCode)
         OP_LOAD, OP_STORE: begin
            operation = ALU_ADD;
            illegal   = 1'b0;
         end
         OP_BRANCH: begin
            operation = ALU_SUB;
            illegal   = 1'b0;
         end
         OP_RTYPE, OP_ITYPE: begin
            // Immediates carry no funct7, so instr[30] only matters for SRAI.
            if ((opCode == OP_ITYPE) && (funct[2:0] != 3'b101))
               f_eff[3] = 1'b0;
            f_dec     = decode_funct(f_eff);
            illegal   = f_dec[4];
            operation = f_dec[3:0];
         end
         default: begin
            operation = ALU_ILL;
            illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_exec_pipe.sv
// Handshaked ALU execute stage: decode, single-cycle ops, iterative
// one-bit-per-cycle shifter and a single-entry output register.
module alu_exec_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opCode,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [3:0]       operation,
   output logic             illegal
);

   localparam int SHAMT_W = $clog2(WIDTH);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   acc, acc_nxt;
   logic [SHAMT_W-1:0] cnt, cnt_nxt;
   logic [3:0]         shop, shop_nxt;

   logic [3:0]         dec_op;
   logic               dec_ill;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;

   logic               load;
   logic [WIDTH-1:0]   load_result;
   logic [3:0]         load_op;
   logic               load_ill;

   alu_decode u_decode (
      .opCode    (opCode),
      .funct     (funct),
      .operation (dec_op),
      .illegal   (dec_ill)
   );

   function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] v);
      case (op)
         ALU_SLL: return {v[WIDTH-2:0], 1'b0};
         ALU_SRA: return {v[WIDTH-1], v[WIDTH-1:1]};
         default: return {1'b0, v[WIDTH-1:1]};
      endcase
   endfunction

   // Shifts only reach here with a zero shift amount, so they pass op_a through.
   function automatic logic [WIDTH-1:0] compute(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      sa = a;
      sb = b;
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLT: return {{(WIDTH-1){1'b0}}, (sa < sb)};
         ALU_SLL, ALU_SRL, ALU_SRA: return a;
         default: return '0;
      endcase
   endfunction

   assign shamt    = op_b[SHAMT_W-1:0];
   assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      shop_nxt    = shop;
      load        = 1'b0;
      load_result = '0;
      load_op     = dec_op;
      load_ill    = dec_ill;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!dec_ill && is_shift(dec_op) && (shamt != '0)) begin
                  state_nxt = ST_SHIFT;
                  acc_nxt   = op_a;
                  cnt_nxt   = shamt;
                  shop_nxt  = dec_op;
               end else begin
                  load        = 1'b1;
                  load_result = compute(dec_op, op_a, op_b);
                  load_op     = dec_op;
                  load_ill    = dec_ill;
               end
            end
         end
         ST_SHIFT: begin
            acc_nxt = shift_one(shop, acc);
            cnt_nxt = cnt - 1'b1;
            if (cnt == SHAMT_W'(1)) begin
               load        = 1'b1;
               load_result = acc_nxt;
               load_op     = shop;
               load_ill    = 1'b0;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A new load wins over draining the current result in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         acc       <= '0;
         cnt       <= '0;
         shop      <= ALU_AND;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         operation <= ALU_AND;
         illegal   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         shop  <= shop_nxt;
         if (load) begin
            out_valid <= 1'b1;
            result    <= load_result;
            zero      <= (load_result == '0);
            operation <= load_op;
            illegal   <= load_ill;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: a 32-bit instance for the main checks and
// an 8-bit instance for narrow-width wrap and signed compare.
module tb_alu_exec_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, zero, illegal;
   logic [6:0]  opcode;
   logic [3:0]  funct, operation;
   logic [31:0] op_a, op_b, result;

   logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_zero, d8_illegal;
   logic [6:0]  d8_opcode;
   logic [3:0]  d8_funct, d8_operation;
   logic [7:0]  d8_op_a, d8_op_b, d8_result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_pipe #(.WIDTH(32)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opCode(opcode), .funct(funct), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .operation(operation), .illegal(illegal)
   );

   alu_exec_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
      .opCode(d8_opcode), .funct(d8_funct), .op_a(d8_op_a), .op_b(d8_op_b),
      .out_valid(d8_out_valid), .out_ready(d8_out_ready), .result(d8_result),
      .zero(d8_zero), .operation(d8_operation), .illegal(d8_illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request with out_ready high, wait for the result, check it, drain it.
   task automatic run_op(input string tag, input logic [6:0] opc, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_res, input logic [3:0] exp_op);
      int lat;
      in_valid = 1'b1; opcode = opc; funct = fn; op_a = a; op_b = b;
      #1;
      check({tag, "_inrdy"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         check({tag, "_busy"}, in_ready, 0);
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_op"}, operation, exp_op);
      check({tag, "_zero"}, zero, exp_res == 32'd0);
      check({tag, "_ill"}, illegal, exp_op == 4'b1111);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; opcode = '0; funct = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
      d8_in_valid = 1'b0; d8_opcode = '0; d8_funct = '0; d8_op_a = '0; d8_op_b = '0;
      d8_out_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("rst_vld", out_valid, 0);
      check("rst_res", result, 0);
      check("rst_zero", zero, 1);
      check("rst_op", operation, 4'b0000);
      check("rst_ill", illegal, 0);
      check("rst_inrdy", in_ready, 1);

      run_op("add",     7'b0110011, 4'b0000, 32'd5,        32'd7,        0, 32'd12,        4'b0010);
      run_op("sub0",    7'b0110011, 4'b1000, 32'd7,        32'd7,        0, 32'd0,         4'b0110);
      run_op("subwrap", 7'b0110011, 4'b1000, 32'd0,        32'd1,        0, 32'hFFFFFFFF,  4'b0110);
      run_op("branch",  7'b1100011, 4'b0101, 32'd3,        32'd3,        0, 32'd0,         4'b0110);
      run_op("iadd",    7'b0010011, 4'b1000, 32'd10,       32'd3,        0, 32'd13,        4'b0010);
      run_op("load",    7'b0000011, 4'b1111, 32'd100,      32'hFFFFFFFC, 0, 32'd96,        4'b0010);
      run_op("store",   7'b0100011, 4'b0000, 32'h7FFFFFFF, 32'd1,        0, 32'h80000000,  4'b0010);
      run_op("and",     7'b0110011, 4'b0111, 32'hF0F0,     32'hFF00,     0, 32'hF000,      4'b0000);
      run_op("or",      7'b0110011, 4'b0110, 32'hF0F0,     32'h0F0F,     0, 32'hFFFF,      4'b0001);
      run_op("xor",     7'b0110011, 4'b0100, 32'hFFFF,     32'h00FF,     0, 32'hFF00,      4'b0011);
      run_op("slt1",    7'b0110011, 4'b0010, 32'hFFFFFFFF, 32'd1,        0, 32'd1,         4'b0111);
      run_op("slt0",    7'b0110011, 4'b0010, 32'd1,        32'hFFFFFFFF, 0, 32'd0,         4'b0111);
      run_op("sra4",    7'b0110011, 4'b1101, 32'h80000000, 32'd4,        4, 32'hF8000000,  4'b1101);
      run_op("srai4",   7'b0010011, 4'b1101, 32'hF0000000, 32'd4,        4, 32'hFF000000,  4'b1101);
      run_op("sll0",    7'b0110011, 4'b0001, 32'h1234,     32'h20,       0, 32'h1234,      4'b0100);
      run_op("srl1",    7'b0110011, 4'b0101, 32'hF0,       32'd1,        1, 32'h78,        4'b0101);
      run_op("sll31",   7'b0110011, 4'b0001, 32'd1,        32'd31,      31, 32'h80000000,  4'b0100);
      run_op("illop",   7'b1111111, 4'b0000, 32'd9,        32'd9,        0, 32'd0,         4'b1111);
      run_op("illfn",   7'b0110011, 4'b0011, 32'd9,        32'd9,        0, 32'd0,         4'b1111);

      // back-pressure: A stalls in the output register while B waits
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 7'b0110011; funct = 4'b0000; op_a = 32'd1; op_b = 32'd1;
      tick();
      op_a = 32'd2; op_b = 32'd2;
      for (int i = 0; i < 5; i++) begin
         check("bp_inrdy", in_ready, 0);
         check("bp_vld", out_valid, 1);
         check("bp_res", result, 32'd2);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_inrdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp_b_vld", out_valid, 1);
      check("bp_b_res", result, 32'd4);
      tick();
      check("bp_empty", out_valid, 0);

      // back-to-back throughput
      in_valid = 1'b1; op_a = 32'd10; op_b = 32'd1;
      tick();
      check("tp_r0", result, 32'd11);
      op_a = 32'd20;
      #1;
      check("tp_inrdy", in_ready, 1);
      tick();
      check("tp_r1", result, 32'd21);
      check("tp_vld", out_valid, 1);
      in_valid = 1'b0;
      tick();
      check("tp_empty", out_valid, 0);

      // inputs changed after accept must not disturb an in-flight shift
      in_valid = 1'b1; opcode = 7'b0110011; funct = 4'b0101; op_a = 32'h100; op_b = 32'd3;
      tick();
      in_valid = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'd1; opcode = 7'b1111111;
      repeat (2) tick();
      check("hold_busy", out_valid, 0);
      tick();
      check("hold_vld", out_valid, 1);
      check("hold_res", result, 32'h20);
      tick();

      // reset in the middle of a shift
      in_valid = 1'b1; opcode = 7'b0110011; funct = 4'b0001; op_a = 32'd1; op_b = 32'd10;
      tick();
      in_valid = 1'b0;
      tick();
      check("rsh_busy", in_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rsh_vld", out_valid, 0);
      check("rsh_inrdy", in_ready, 1);
      check("rsh_zero", zero, 1);
      repeat (12) tick();
      check("rsh_noload", out_valid, 0);

      // reset while a result is held
      out_ready = 1'b0;
      in_valid = 1'b1; funct = 4'b0000; op_a = 32'd3; op_b = 32'd4;
      tick();
      in_valid = 1'b0;
      check("rov_vld_before", out_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rov_vld", out_valid, 0);
      check("rov_res", result, 0);
      check("rov_op", operation, 4'b0000);
      out_ready = 1'b1;

      // 8-bit instance
      d8_in_valid = 1'b1; d8_opcode = 7'b0110011; d8_funct = 4'b0000;
      d8_op_a = 8'hFF; d8_op_b = 8'h01;
      tick();
      d8_in_valid = 1'b0;
      check("w8_add_vld", d8_out_valid, 1);
      check("w8_add_res", d8_result, 8'h00);
      check("w8_add_zero", d8_zero, 1);
      tick();
      d8_in_valid = 1'b1; d8_funct = 4'b0010; d8_op_a = 8'hFF; d8_op_b = 8'h01;
      tick();
      d8_in_valid = 1'b0;
      check("w8_slt_res", d8_result, 8'h01);
      check("w8_slt_op", d8_operation, 4'b0111);
      tick();
      d8_in_valid = 1'b1; d8_funct = 4'b0001; d8_op_a = 8'h81; d8_op_b = 8'h09;
      tick();
      d8_in_valid = 1'b0;
      check("w8_sll_busy", d8_out_valid, 0);
      tick();
      check("w8_sll_vld", d8_out_valid, 1);
      check("w8_sll_res", d8_result, 8'h02);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
